// File: rtl/ecc_pkg.sv
// SECDED code-geometry helpers shared by the ECC encoder, decoder and scrubber.
package ecc_pkg;

   function automatic int get_parity_width(int data_width);
      int p;
      p = 1;
      while ((1 << p) < data_width + p + 1) p++;
      return p;
   endfunction

   function automatic int get_cw_width(int data_width);
      return data_width + get_parity_width(data_width);
   endfunction

endpackage

// File: rtl/ecc_scrubber_if.sv
// Bank port shared by the scrubber and the external master / SRAM side.
interface ecc_scrubber_if #(
   parameter int AddrWidth = 8,
   parameter int EncWidth  = 39
);
   logic                 ext_req_i;
   logic                 ext_we_i;
   logic [AddrWidth-1:0] ext_addr_i;
   logic                 bank_req_o;
   logic                 bank_we_o;
   logic [AddrWidth-1:0] bank_addr_o;
   logic [EncWidth-1:0]  bank_wdata_o;
   logic [EncWidth-1:0]  bank_rdata_i;

   modport master (
      input  ext_req_i, ext_we_i, ext_addr_i, bank_rdata_i,
      output bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o
   );

   modport slave (
      output ext_req_i, ext_we_i, ext_addr_i, bank_rdata_i,
      input  bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o
   );
endinterface

// File: rtl/ecc_decode.sv
// SECDED decoder: corrects single-bit errors, flags overall-parity and double errors.
module ecc_decode
   import ecc_pkg::*;
#(
   parameter  int DataWidth = 32,
   localparam int CwWidth   = get_cw_width(DataWidth),
   localparam int EncWidth  = CwWidth + 1
) (
   input  logic [EncWidth-1:0]  code,
   output logic [DataWidth-1:0] data,
   output logic                 single_err,
   output logic                 parity_err,
   output logic                 double_err
);
   localparam int ParWidth = get_parity_width(DataWidth);

   logic [ParWidth-1:0] syn;
   logic                overall;

   always_comb begin
      syn = '0;
      for (int i = 1; i <= CwWidth; i++)
         if (code[i]) syn = syn ^ i[ParWidth-1:0];
      overall    = ^code;
      single_err = 1'b0;
      parity_err = 1'b0;
      double_err = 1'b0;
      if (overall) begin
         if (syn == '0) parity_err = 1'b1;
         else if (int'(syn) <= CwWidth) single_err = 1'b1;
         else double_err = 1'b1;
      end else if (syn != '0) begin
         double_err = 1'b1;
      end
   end

   for (genvar i = 1; i <= CwWidth; i++) begin : g_pos
      if ((i & (i - 1)) != 0) begin : g_dat
         assign data[i - 1 - $clog2(i)] =
            code[i] ^ (single_err && syn == ParWidth'(i));
      end
   end

endmodule

// File: rtl/ecc_encode.sv
// SECDED encoder: Hamming bits at positions 1..CwWidth, overall parity at bit 0.
module ecc_encode
   import ecc_pkg::*;
#(
   parameter  int DataWidth = 32,
   localparam int CwWidth   = get_cw_width(DataWidth),
   localparam int EncWidth  = CwWidth + 1
) (
   input  logic [DataWidth-1:0] data,
   output logic [EncWidth-1:0]  code
);
   localparam int ParWidth = get_parity_width(DataWidth);

   logic [EncWidth-1:0] raw;
   logic                par;

   assign raw[0] = 1'b0;

   // Data fills the non-power-of-two positions in ascending order.
   for (genvar i = 1; i <= CwWidth; i++) begin : g_pos
      if ((i & (i - 1)) == 0) begin : g_chk
         assign raw[i] = 1'b0;
      end else begin : g_dat
         assign raw[i] = data[i - 1 - $clog2(i)];
      end
   end

   always_comb begin
      code = raw;
      par  = 1'b0;
      for (int p = 0; p < ParWidth; p++) begin
         par = 1'b0;
         for (int i = 1; i <= CwWidth; i++)
            if (i[p]) par = par ^ raw[i];
         code[1 << p] = par;
      end
      code[0] = ^code[CwWidth:1];
   end

endmodule

// File: rtl/ecc_scrubber.sv
// Background SRAM scrubber: read, check, write back corrected words, yield to external master.
module ecc_scrubber
   import ecc_pkg::*;
#(
   parameter  int BankSize     = 256,
   parameter  int DataWidth    = 32,
   parameter  int CounterWidth = 16,
   localparam int AddrWidth    = $clog2(BankSize),
   localparam int EncWidth     = get_cw_width(DataWidth) + 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    scrub_trigger_i,
   output logic                    scrub_busy_o,
   output logic [CounterWidth-1:0] corrected_cnt_o,
   output logic [CounterWidth-1:0] uncorrectable_cnt_o,
   ecc_scrubber_if.master          bus
);
   typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_e;

   state_e                  state_q, state_d;
   logic [AddrWidth-1:0]    addr_q, addr_d, addr_nxt;
   logic [CounterWidth-1:0] corr_q, corr_d;
   logic [CounterWidth-1:0] unc_q, unc_d;
   logic [EncWidth-1:0]     wdata_q, wdata_d;
   logic                    req, we;

   logic [DataWidth-1:0] dec_data;
   logic                 dec_single, dec_parity, dec_double;
   logic [EncWidth-1:0]  enc_code;

   ecc_decode #(.DataWidth(DataWidth)) u_dec (
      .code      (bus.bank_rdata_i),
      .data      (dec_data),
      .single_err(dec_single),
      .parity_err(dec_parity),
      .double_err(dec_double)
   );

   ecc_encode #(.DataWidth(DataWidth)) u_enc (
      .data(dec_data),
      .code(enc_code)
   );

   assign addr_nxt = (addr_q == AddrWidth'(BankSize - 1)) ? '0 : addr_q + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         corr_q  <= '0;
         unc_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         corr_q  <= corr_d;
         unc_q   <= unc_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      corr_d  = corr_q;
      unc_d   = unc_q;
      wdata_d = wdata_q;
      req     = 1'b0;
      we      = 1'b0;
      unique case (state_q)
         IDLE: if (scrub_trigger_i) state_d = READ;
         READ: begin
            if (!bus.ext_req_i) begin
               req     = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (dec_single || dec_parity) begin
               wdata_d = enc_code;
               corr_d  = (corr_q == '1) ? corr_q : corr_q + 1'b1;
               state_d = WRITE;
            end else begin
               if (dec_double) unc_d = (unc_q == '1) ? unc_q : unc_q + 1'b1;
               addr_d  = addr_nxt;
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (!bus.ext_req_i) begin
               req     = 1'b1;
               we      = 1'b1;
               addr_d  = addr_nxt;
               state_d = IDLE;
            end else if (bus.ext_we_i && bus.ext_addr_i == addr_q) begin
               // Master overwrote the word; our correction is now stale.
               addr_d  = addr_nxt;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.bank_req_o      = req;
   assign bus.bank_we_o       = we;
   assign bus.bank_addr_o     = addr_q;
   assign bus.bank_wdata_o    = wdata_q;
   assign scrub_busy_o        = (state_q != IDLE);
   assign corrected_cnt_o     = corr_q;
   assign uncorrectable_cnt_o = unc_q;

endmodule
